// File: rtl/fir_mdc_package.sv
// fir_mdc_package: shared FSM state, control/flag bundles and width helpers for the FIR core
package fir_mdc_package;
  localparam int unsigned MAX_TAPS = 16;
  localparam int unsigned MAX_COEFF_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fir_state_e;
  typedef struct packed {
    logic start;
    logic [31:0] len;
    logic [5:0] shift;
    logic [MAX_TAPS-1:0][MAX_COEFF_WIDTH-1:0] coeff;
  } ctrl_fir_core_t;
  typedef struct packed {
    logic busy;
    logic done;
    logic [31:0] cnt;
  } flags_fir_core_t;
  function automatic int acc_width(input int d, input int c, input int n);
    return d + c + $clog2(n);
  endfunction
endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// hwpe_stream_intf_stream: valid/ready/data/strb streaming handshake bundle
interface hwpe_stream_intf_stream #(
  parameter int DATA_WIDTH = 32
) ();
  logic valid;
  logic ready;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH/8-1:0] strb;
  modport source (output valid, data, strb, input ready);
  modport sink (input valid, data, strb, output ready);
endinterface

// File: rtl/fir_mdc_sat_shift.sv
// fir_mdc_sat_shift: round-half-up, arithmetic right shift and signed saturation of the accumulator
module fir_mdc_sat_shift #(
  parameter int ACC_W = 51,
  parameter int DATA_WIDTH = 32
) (
  input logic signed [ACC_W-1:0] acc_i,
  input logic [5:0] shift_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam int SUM_W = ACC_W + 1;
  logic signed [SUM_W-1:0] rnd;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sh;
  logic ovf;
  // one extra bit keeps the rounding add from wrapping before the shift
  always_comb begin
    rnd = (shift_i == 6'd0) ? '0 : SUM_W'(1) << (shift_i - 6'd1);
    sum = SUM_W'(acc_i) + rnd;
    sh = sum >>> shift_i;
    ovf = sh[SUM_W-1:DATA_WIDTH-1] != {(SUM_W-DATA_WIDTH+1){sh[SUM_W-1]}};
    data_o = !ovf ? sh[DATA_WIDTH-1:0] :
             sh[SUM_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
endmodule

// File: rtl/fir_mdc_fir_core.sv
// fir_mdc_fir_core: streaming N-tap FIR job engine with latency-1 registered output
module fir_mdc_fir_core
  import fir_mdc_package::*;
#(
  parameter int N_TAPS = 8,
  parameter int DATA_WIDTH = 32,
  parameter int COEFF_WIDTH = 16
) (
  input logic clk_i,
  input logic rst_ni,
  input logic clear_i,
  input logic start_i,
  input logic [31:0] len_i,
  input logic [5:0] shift_i,
  input logic [N_TAPS-1:0][COEFF_WIDTH-1:0] coeff_i,
  hwpe_stream_intf_stream.sink x_i,
  hwpe_stream_intf_stream.source y_o,
  output logic busy_o,
  output logic done_o,
  output logic [31:0] cnt_o
);
  localparam int ACC_W = acc_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS);
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  fir_state_e state_q, state_d;
  ctrl_fir_core_t ctrl, cfg_q;
  flags_fir_core_t flags;
  logic [31:0] rem_q, cnt_q;
  logic done_q, y_valid_q, x_ready, x_hs, y_hs, go, zero_start;
  logic [DATA_WIDTH-1:0] y_data_q, y_sat;
  logic signed [DATA_WIDTH-1:0] dl_q [N_TAPS-1];
  logic signed [DATA_WIDTH-1:0] win [N_TAPS];
  logic signed [PROD_W-1:0] prod [N_TAPS];
  logic signed [ACC_W-1:0] acc;
  logic unused_cfg, unused_strb;
  assign go = state_q == IDLE && start_i && len_i != 32'd0 && !clear_i;
  assign zero_start = state_q == IDLE && start_i && len_i == 32'd0 && !clear_i;
  assign x_ready = state_q == RUN && rem_q != 32'd0 && (!y_valid_q || y_o.ready);
  assign x_hs = x_i.valid && x_ready;
  assign y_hs = y_valid_q && y_o.ready;
  // job request bundle, coefficients sign-extended to the package width
  always_comb begin
    ctrl = '0;
    ctrl.start = start_i;
    ctrl.len = len_i;
    ctrl.shift = shift_i;
    for (int i = 0; i < N_TAPS; i++) ctrl.coeff[i] = MAX_COEFF_WIDTH'($signed(coeff_i[i]));
  end
  // next state and status flags; clear wins over everything and suppresses done
  always_comb begin
    state_d = clear_i ? IDLE :
              go ? RUN :
              (state_q == RUN && x_hs && rem_q == 32'd1) ? FLUSH :
              (state_q == FLUSH && y_hs) ? IDLE : state_q;
    flags = '0;
    flags.busy = state_q != IDLE;
    flags.done = done_q || (state_q == FLUSH && y_hs && !clear_i);
    flags.cnt = cnt_q;
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end
  // job configuration, remaining-input and output counters, zero-length done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= zero_start;
      if (clear_i) begin
        rem_q <= '0;
        cnt_q <= '0;
      end else if (go) begin
        cfg_q <= ctrl;
        rem_q <= ctrl.len;
        cnt_q <= '0;
      end else begin
        if (x_hs) rem_q <= rem_q - 32'd1;
        if (y_hs) cnt_q <= cnt_q + 32'd1;
      end
    end
  end
  // tap window: the incoming sample is the newest tap
  always_comb begin
    win[0] = x_i.data;
    for (int i = 1; i < N_TAPS; i++) win[i] = dl_q[i-1];
    acc = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      prod[i] = win[i] * $signed(cfg_q.coeff[i][COEFF_WIDTH-1:0]);
      acc = acc + ACC_W'(prod[i]);
    end
  end
  fir_mdc_sat_shift #(.ACC_W(ACC_W), .DATA_WIDTH(DATA_WIDTH)) i_sat (
    .acc_i(acc),
    .shift_i(cfg_q.shift),
    .data_o(y_sat)
  );
  // delay line and output register; a new result may replace one being handed off
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_TAPS-1; i++) dl_q[i] <= '0;
      y_valid_q <= 1'b0;
      y_data_q <= '0;
    end else if (clear_i || go) begin
      for (int i = 0; i < N_TAPS-1; i++) dl_q[i] <= '0;
      if (clear_i) y_valid_q <= 1'b0;
    end else if (x_hs) begin
      for (int i = 0; i < N_TAPS-1; i++) dl_q[i] <= win[i];
      y_valid_q <= 1'b1;
      y_data_q <= y_sat;
    end else if (y_hs) begin
      y_valid_q <= 1'b0;
    end
  end
  assign unused_cfg = ^{cfg_q.start, cfg_q.len, cfg_q.coeff};
  assign unused_strb = ^x_i.strb;
  assign x_i.ready = x_ready;
  assign y_o.valid = y_valid_q;
  assign y_o.data = y_data_q;
  assign y_o.strb = '1;
  assign busy_o = flags.busy;
  assign done_o = flags.done;
  assign cnt_o = flags.cnt;
endmodule

// File: tb/tb_fir_mdc_fir_core.sv
// tb_fir_mdc_fir_core: scoreboard bench for the FIR core against a behavioural model
module tb_fir_mdc_fir_core;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic [31:0] len = '0;
  logic [5:0] shift = '0;
  logic [N-1:0][15:0] coeff = '0;
  logic busy, done;
  logic [31:0] cnt;
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) x_s ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) y_s ();
  fir_mdc_fir_core #(.N_TAPS(N), .DATA_WIDTH(32), .COEFF_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .start_i(start),
    .len_i(len), .shift_i(shift), .coeff_i(coeff),
    .x_i(x_s), .y_o(y_s),
    .busy_o(busy), .done_o(done), .cnt_o(cnt)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, done_seen = 0, outs = 0, cyc = 0, first_x = -1, last_x = -1;
  logic [31:0] q[$];
  logic [31:0] last_y = '0;
  longint m_c[N];
  longint m_dl[N];
  int m_sh = 0;
  bit rnd_ready = 0;
  logic [N-1:0][15:0] cv;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input longint xn);
    longint acc;
    for (int i = N-1; i > 0; i--) m_dl[i] = m_dl[i-1];
    m_dl[0] = xn;
    acc = 0;
    for (int i = 0; i < N; i++) acc += m_dl[i] * m_c[i];
    if (m_sh > 0) acc += longint'(1) << (m_sh - 1);
    acc = acc >>> m_sh;
    if (acc > 64'sd2147483647) acc = 64'sd2147483647;
    if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    return acc[31:0];
  endfunction
  always @(negedge clk) if (rst_ni) begin
    cyc++;
    if (x_s.valid && x_s.ready) begin
      q.push_back(model(longint'($signed(x_s.data))));
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
    end
    if (y_s.valid && y_s.ready) begin
      outs++;
      last_y = y_s.data;
      if (q.size() == 0) chk("spurious_y", 32'd1, 32'd0);
      else chk("y_data", y_s.data, q.pop_front());
    end
    if (y_s.valid && !y_s.ready) chk("x_ready_stall", {31'd0, x_s.ready}, 32'd0);
    if (done) done_seen++;
  end
  always @(posedge clk) begin
    #1;
    y_s.ready = rnd_ready ? ($urandom_range(99) < 30) : 1'b1;
  end
  task automatic start_job(input int l, input int sh, input logic [N-1:0][15:0] c, input bit upd);
    start = 1'b1;
    len = l;
    shift = sh[5:0];
    coeff = c;
    if (upd) begin
      for (int i = 0; i < N; i++) begin
        m_c[i] = longint'($signed(c[i]));
        m_dl[i] = 0;
      end
      m_sh = sh;
      first_x = -1;
      outs = 0;
      done_seen = 0;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic push_x(input logic [31:0] d);
    int t = 0;
    x_s.valid = 1'b1;
    x_s.data = d;
    @(negedge clk);
    while (!x_s.ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!x_s.ready) begin
      chk("x_hs_timeout", 32'd0, 32'd1);
      x_s.valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 x_s.valid = 1'b0;
  endtask
  task automatic wait_done(input int n);
    int t = 0;
    while (done_seen == 0 && t < 300) begin
      @(posedge clk);
      #1 t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_seen, 1);
    chk("out_count", outs, n);
    chk("cnt", cnt, n);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("sb_empty", q.size(), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    x_s.valid = 1'b0;
    x_s.data = '0;
    x_s.strb = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_yvalid", {31'd0, y_s.valid}, 32'd0);
    chk("rst_ydata", y_s.data, 32'd0);
    chk("rst_xready", {31'd0, x_s.ready}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) cv[i] = 16'd1;
    start_job(10, 0, cv, 1);
    for (int i = 1; i <= 10; i++) push_x(i);
    wait_done(10);
    chk("throughput", last_x - first_x, 9);
    chk("last_y_ramp", last_y, 32'd52);
    cv = '0;
    cv[0] = 16'h7FFF;
    start_job(2, 0, cv, 1);
    push_x(32'h7FFFFFFF);
    push_x(32'h80000000);
    wait_done(2);
    chk("sat_neg", last_y, 32'h80000000);
    cv = '0;
    cv[0] = 16'd3;
    start_job(2, 1, cv, 1);
    push_x(32'd1);
    push_x(32'hFFFFFFFF);
    wait_done(2);
    chk("round_neg", last_y, 32'hFFFFFFFF);
    for (int i = 0; i < N; i++) cv[i] = 16'($urandom);
    rnd_ready = 1;
    start_job(4, 3, cv, 1);
    for (int i = 0; i < 4; i++) push_x($urandom);
    wait_done(4);
    rnd_ready = 0;
    start_job(0, 0, cv, 1);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 chk("len0_done_end", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("len0_outs", outs, 0);
    for (int i = 0; i < N; i++) cv[i] = 16'd1;
    start_job(3, 0, cv, 1);
    push_x(32'd5);
    start_job(7, 2, '0, 0);
    push_x(32'd6);
    push_x(32'd7);
    wait_done(3);
    chk("busy_start_last", last_y, 32'd18);
    for (int i = 0; i < N; i++) cv[i] = 16'(i + 1);
    start_job(6, 0, cv, 1);
    for (int i = 0; i < 3; i++) push_x(32'd10 + i);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    q.delete();
    chk("clr_busy", {31'd0, busy}, 32'd0);
    chk("clr_yvalid", {31'd0, y_s.valid}, 32'd0);
    chk("clr_cnt", cnt, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("clr_no_done", done_seen, 0);
    start_job(4, 0, cv, 1);
    for (int i = 0; i < 4; i++) push_x(32'd100 * (i + 1));
    wait_done(4);
    start_job(6, 0, cv, 1);
    for (int i = 0; i < 3; i++) push_x(32'hFFFFFF00 + i);
    rst_ni = 1'b0;
    #1;
    q.delete();
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_yvalid", {31'd0, y_s.valid}, 32'd0);
    chk("arst_cnt", cnt, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 rst_ni = 1'b1;
    chk("arst_no_done", done_seen, 0);
    start_job(4, 0, cv, 1);
    for (int i = 0; i < 4; i++) push_x(32'd100 * (i + 1));
    wait_done(4);
    chk("fresh_after_rst", last_y, 32'd2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_mdc_fir_core.md
FIR_MDC_FIR_CORE -- requirements
Module: fir_mdc_fir_core

Interface
REQ-001 SHALL have parameter N_TAPS, default 8, number of FIR taps (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, sample width, signed two's complement.
REQ-003 SHALL have parameter COEFF_WIDTH, default 16, coefficient width, signed two's complement.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear_i  input  1  synchronous soft clear.
REQ-007 SHALL have port start_i  input  1  one-cycle job start pulse.
REQ-008 SHALL have port len_i  input  32  number of input samples in the job, sampled on start.
REQ-009 SHALL have port shift_i  input  6  arithmetic right shift applied to the accumulator, sampled on start.
REQ-010 SHALL have port coeff_i  input  N_TAPS x COEFF_WIDTH  tap coefficients; coeff[0] multiplies the newest sample; sampled on start.
REQ-011 SHALL have port x_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  input samples (valid/ready/data).
REQ-012 SHALL have port y_o  hwpe_stream_intf_stream.source  DATA_WIDTH  filtered output samples.
REQ-013 SHALL have port busy_o  output  1  high while not IDLE.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse at job end.
REQ-015 SHALL have port cnt_o  output  32  count of output samples delivered in the current job.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and FLUSH.
REQ-017 SHALL move IDLE->RUN on start_i with len_i>0, latching len, shift and coefficients, zeroing the delay line and zeroing cnt_o.
REQ-018 SHALL, on start_i with len_i==0, stay in IDLE and pulse done_o in the following cycle.
REQ-019 SHALL ignore start_i outside IDLE.
REQ-020 SHALL assert x_i.ready only in RUN, with remaining inputs >0 and (y_o.valid==0 or y_o.ready==1).
REQ-021 SHALL, on each x handshake, shift the sample into the delay line and register the result into the y output register, asserting y_o.valid in the next cycle (latency 1).
REQ-022 SHALL compute the result as the sum of N_TAPS products in a full-precision accumulator of DATA_WIDTH+COEFF_WIDTH+clog2(N_TAPS) bits, with no intermediate truncation.
REQ-023 SHALL add a rounding term 2^(shift-1) when shift>0, arithmetic-shift right by shift, and saturate to the signed DATA_WIDTH range.
REQ-024 SHALL hold y_o.data and y_o.valid stable until y_o.ready; y_o.strb SHALL be all ones.
REQ-025 SHALL allow an x handshake and a y handshake in the same cycle with no bubble (one sample per cycle throughput).
REQ-026 SHALL move RUN->FLUSH on acceptance of the last input sample.
REQ-027 SHALL move FLUSH->IDLE on the y handshake of the last output, pulsing done_o in that cycle.
REQ-028 SHALL increment cnt_o on each y handshake; cnt_o holds its value after done until the next start.
REQ-029 SHALL, on clear_i, enter IDLE, drop y_o.valid, zero the delay line and cnt_o, and not pulse done_o; clear_i has priority over start_i.

Reset
REQ-030 SHALL, on rst_ni low, asynchronously set the state to IDLE and set y_o.valid, y_o.data, busy_o, done_o, cnt_o, the delay line and the latched configuration to 0.

Structure
REQ-031 SHALL take the FSM state enum, the ctrl_fir_core_t struct (start, len, shift, coeff) and the flags_fir_core_t struct (busy, done, cnt) from fir_mdc_package.
REQ-032 SHALL place the rounding/shift/saturation logic in one combinational sub-module, fir_mdc_sat_shift.

Verification
REQ-033 SHALL cover: N_TAPS=8, all coefficients=1, shift=0, len=10, x=1..10, y always ready -> y=1,3,6,10,15,21,28,36,44,52; then done pulse; cnt=10.
REQ-034 SHALL cover: coeff[0]=0x7FFF, others 0, shift=0, x=0x7FFFFFFF -> y=0x7FFFFFFF (saturated); x=0x80000000 -> y=0x80000000.
REQ-035 SHALL cover: coeff[0]=3, shift=1, x=1 -> y=2 (1.5 rounded); x=-1 -> y=-1.
REQ-036 SHALL cover: len=4 with y_o.ready random at 30% -> exactly 4 outputs with no loss or duplication; x_i.ready low whenever y is stalled and valid.
REQ-037 SHALL cover: start with len=0 -> no outputs, done one cycle later; start while busy -> ignored.
REQ-038 SHALL cover: clear_i, or rst_ni low, asserted mid-job at sample 3 -> IDLE, y_o.valid=0, no done; the next job output matches a fresh run.
